// File: rtl/time_set_ctrl_pkg.sv
// Shared edit-state codes, BCD digit limits and digit-step helper for the time-set controller.
package time_set_ctrl_pkg;

    typedef logic [4:0] state_t;

    localparam state_t ST_RUN     = 5'd0;
    localparam state_t ST_H_TENS  = 5'd2;
    localparam state_t ST_H_UNITS = 5'd4;
    localparam state_t ST_M_TENS  = 5'd6;
    localparam state_t ST_M_UNITS = 5'd8;

    localparam logic [3:0] LIM_H_TENS     = 4'd2;
    localparam logic [3:0] LIM_H_UNITS_HI = 4'd3;
    localparam logic [3:0] LIM_M_TENS     = 4'd5;
    localparam logic [3:0] LIM_UNITS      = 4'd9;

    // Any digit at or past its limit (including invalid BCD) wraps to zero.
    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for an asynchronous key level plus a one-cycle rising-edge pulse.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: mode key walks the BCD digits, inc key steps the selected digit.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30000000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic [4:0] Status,
    output logic [7:0] newHour,
    output logic [7:0] newMinute,
    output logic       run_en
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          mode_ev, inc_ev;
    state_t        state, state_nx;
    logic [7:0]    hour_nx, min_nx;
    logic [CW-1:0] tcnt, tcnt_nx;
    logic [3:0]    ht, hu;

    key_edge u_mode (.clk(CP), .rst(CR), .key(key_mode), .rise(mode_ev));
    key_edge u_inc  (.clk(CP), .rst(CR), .key(key_inc),  .rise(inc_ev));

    always_comb begin
        state_nx = state;
        hour_nx  = newHour;
        min_nx   = newMinute;
        tcnt_nx  = tcnt;
        ht       = newHour[7:4];
        hu       = newHour[3:0];
        if (state == ST_RUN) begin
            tcnt_nx = '0;
            if (mode_ev) begin
                state_nx = ST_H_TENS;
                hour_nx  = cur_hour;
                min_nx   = cur_min;
            end
        end else if (mode_ev) begin
            // Mode wins over a coincident inc event, which is simply dropped.
            tcnt_nx = '0;
            case (state)
                ST_H_TENS:  state_nx = ST_H_UNITS;
                ST_H_UNITS: state_nx = ST_M_TENS;
                ST_M_TENS:  state_nx = ST_M_UNITS;
                default:    state_nx = ST_RUN;
            endcase
        end else if (inc_ev) begin
            tcnt_nx = '0;
            case (state)
                ST_H_TENS: begin
                    ht = step_digit(newHour[7:4], LIM_H_TENS);
                    if (ht == LIM_H_TENS && hu > LIM_H_UNITS_HI)
                        hu = LIM_H_UNITS_HI;
                    hour_nx = {ht, hu};
                end
                ST_H_UNITS:
                    hour_nx = {newHour[7:4], step_digit(newHour[3:0],
                               (newHour[7:4] == LIM_H_TENS) ? LIM_H_UNITS_HI : LIM_UNITS)};
                ST_M_TENS:
                    min_nx = {step_digit(newMinute[7:4], LIM_M_TENS), newMinute[3:0]};
                ST_M_UNITS:
                    min_nx = {newMinute[7:4], step_digit(newMinute[3:0], LIM_UNITS)};
                default: state_nx = ST_RUN;
            endcase
        end else if (tcnt == TO_LAST) begin
            state_nx = ST_RUN;
            tcnt_nx  = '0;
        end else begin
            tcnt_nx = tcnt + 1'b1;
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state     <= ST_RUN;
            run_en    <= 1'b1;
            newHour   <= '0;
            newMinute <= '0;
            tcnt      <= '0;
        end else begin
            state     <= state_nx;
            run_en    <= (state_nx == ST_RUN);
            newHour   <= hour_nx;
            newMinute <= min_nx;
            tcnt      <= tcnt_nx;
        end
    end

    assign Status = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected outputs queued at stimulus, compared when the DUT acts.
module tb_time_set_ctrl;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [7:0] cur_hour = 8'h00;
    logic [7:0] cur_min = 8'h00;
    logic [4:0] Status;
    logic [7:0] newHour, newMinute;
    logic       run_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [4:0] st;
        logic [7:0] h;
        logic [7:0] m;
        logic       re;
    } exp_t;

    exp_t       sbq[$];
    logic [4:0] prev_st = 5'd0;

    time_set_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .CP(CP), .CR(CR), .key_mode(key_mode), .key_inc(key_inc),
        .cur_hour(cur_hour), .cur_min(cur_min), .Status(Status),
        .newHour(newHour), .newMinute(newMinute), .run_en(run_en)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [4:0] st, input logic [7:0] h,
                            input logic [7:0] m, input logic re);
        exp_t e;
        e.tag = tag; e.st = st; e.h = h; e.m = m; e.re = re;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({e.tag, ".Status"},    32'(Status),    32'(e.st));
            check({e.tag, ".newHour"},   32'(newHour),   32'(e.h));
            check({e.tag, ".newMinute"}, 32'(newMinute), 32'(e.m));
            check({e.tag, ".run_en"},    32'(run_en),    32'(e.re));
            prev_st = e.st;
        end
    endtask

    // Key goes high before edge k; the effect must be absent at k+1 and present at k+2.
    task automatic press(input string tag, input logic m, input logic i, input int hold,
                         input logic [4:0] st, input logic [7:0] h, input logic [7:0] mi,
                         input logic re);
        push_exp(tag, st, h, mi, re);
        @(negedge CP);
        key_mode = m;
        key_inc  = i;
        @(posedge CP);
        @(posedge CP); #1;
        check({tag, ".early"}, 32'(Status), 32'(prev_st));
        @(posedge CP); #1;
        pop_cmp();
        repeat (hold) @(posedge CP);
        @(negedge CP);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (2) @(posedge CP);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_hour = 8'h17;
        cur_min  = 8'h42;
        repeat (3) @(posedge CP);
        #1;
        push_exp("reset", 5'd0, 8'h00, 8'h00, 1'b1);
        pop_cmp();
        @(negedge CP);
        CR = 1'b0;
        repeat (2) @(posedge CP);

        press("inc_in_run", 1'b0, 1'b1, 0, 5'd0, 8'h00, 8'h00, 1'b1);
        press("enter",      1'b1, 1'b0, 0, 5'd2, 8'h17, 8'h42, 1'b0);
        press("ht_1to2",    1'b0, 1'b1, 0, 5'd2, 8'h23, 8'h42, 1'b0);
        press("ht_2to0",    1'b0, 1'b1, 0, 5'd2, 8'h03, 8'h42, 1'b0);
        press("ht_0to1",    1'b0, 1'b1, 0, 5'd2, 8'h13, 8'h42, 1'b0);
        press("ht_1to2b",   1'b0, 1'b1, 0, 5'd2, 8'h23, 8'h42, 1'b0);
        press("to_hu",      1'b1, 1'b0, 0, 5'd4, 8'h23, 8'h42, 1'b0);
        press("hu_3to0",    1'b0, 1'b1, 0, 5'd4, 8'h20, 8'h42, 1'b0);
        press("hu_0to1",    1'b0, 1'b1, 0, 5'd4, 8'h21, 8'h42, 1'b0);
        press("to_mt",      1'b1, 1'b0, 0, 5'd6, 8'h21, 8'h42, 1'b0);
        press("mt_4to5",    1'b0, 1'b1, 0, 5'd6, 8'h21, 8'h52, 1'b0);
        press("mt_5to0",    1'b0, 1'b1, 0, 5'd6, 8'h21, 8'h02, 1'b0);
        press("to_mu",      1'b1, 1'b0, 0, 5'd8, 8'h21, 8'h02, 1'b0);
        press("mu_2to3",    1'b0, 1'b1, 0, 5'd8, 8'h21, 8'h03, 1'b0);
        // Hold mode ~100 cycles: exactly one advance, back to RUN and stable.
        push_exp("held_stable", 5'd0, 8'h21, 8'h03, 1'b1);
        press("held_mode",  1'b1, 1'b0, 97, 5'd0, 8'h21, 8'h03, 1'b1);
        pop_cmp();

        cur_hour = 8'h09;
        cur_min  = 8'h59;
        press("enter2",     1'b1, 1'b0, 0, 5'd2, 8'h09, 8'h59, 1'b0);
        press("simul",      1'b1, 1'b1, 0, 5'd4, 8'h09, 8'h59, 1'b0);
        press("to_mt2",     1'b1, 1'b0, 0, 5'd6, 8'h09, 8'h59, 1'b0);
        press("to_mu2",     1'b1, 1'b0, 0, 5'd8, 8'h09, 8'h59, 1'b0);
        push_exp("to_edge",  5'd8, 8'h09, 8'h50, 1'b0);
        push_exp("timeout",  5'd0, 8'h09, 8'h50, 1'b1);
        // Last key event lands at edge E; timeout must fire at E+16, not E+15.
        push_exp("mu_9to0", 5'd8, 8'h09, 8'h50, 1'b0);
        sbq.insert(0, sbq.pop_back());
        @(negedge CP);
        key_inc = 1'b1;
        @(posedge CP);
        @(posedge CP); #1;
        check("mu_9to0.early", 32'(Status), 32'(prev_st));
        @(posedge CP); #1;
        pop_cmp();
        @(negedge CP);
        key_inc = 1'b0;
        repeat (15) @(posedge CP);
        #1;
        pop_cmp();
        @(posedge CP); #1;
        pop_cmp();

        cur_hour = 8'h12;
        cur_min  = 8'h34;
        press("enter3",     1'b1, 1'b0, 0, 5'd2, 8'h12, 8'h34, 1'b0);
        press("to_hu3",     1'b1, 1'b0, 0, 5'd4, 8'h12, 8'h34, 1'b0);
        press("to_mt3",     1'b1, 1'b0, 0, 5'd6, 8'h12, 8'h34, 1'b0);
        // Reset mid-edit with mode held across release: one event at release+2.
        @(negedge CP);
        CR = 1'b1;
        key_mode = 1'b1;
        push_exp("reset_mid", 5'd0, 8'h00, 8'h00, 1'b1);
        @(posedge CP); #1;
        pop_cmp();
        @(posedge CP);
        @(negedge CP);
        CR = 1'b0;
        push_exp("rel_plus1", 5'd0, 8'h00, 8'h00, 1'b1);
        push_exp("rel_plus2", 5'd2, 8'h12, 8'h34, 1'b0);
        push_exp("rel_hold",  5'd2, 8'h12, 8'h34, 1'b0);
        @(posedge CP);
        @(posedge CP); #1;
        pop_cmp();
        @(posedge CP); #1;
        pop_cmp();
        repeat (4) @(posedge CP);
        #1;
        pop_cmp();
        @(negedge CP);
        key_mode = 1'b0;
        repeat (3) @(posedge CP);

        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
